// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-subset control unit:
// opcodes, functs, FSM states, ALU control and datapath mux selects.
package mips_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;

   typedef enum logic [2:0] {
      ALU_AND = 3'b000,
      ALU_OR  = 3'b001,
      ALU_ADD = 3'b010,
      ALU_SUB = 3'b110,
      ALU_SLT = 3'b111
   } alu_ctl_t;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_ADDIEX = 4'd9,
      S_ADDIWB = 4'd10,
      S_JUMP   = 4'd11
   } state_t;

   typedef enum logic [1:0] {
      SRCB_RT     = 2'b00,
      SRCB_FOUR   = 2'b01,
      SRCB_IMM    = 2'b10,
      SRCB_IMM_SH = 2'b11
   } srcb_t;

   typedef enum logic [1:0] {
      PCSRC_ALU    = 2'b00,
      PCSRC_ALUOUT = 2'b01,
      PCSRC_JUMP   = 2'b10
   } pcsrc_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory signal bundle. master = control unit,
// slave = datapath side that supplies instruction fields and flags.
interface multicycle_ctrl_if;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ready;
   logic       mem_req;
   logic       iord;
   logic       irwrite;
   logic       pcen;
   logic [1:0] pcsrc;
   logic       alusrca;
   logic [1:0] alusrcb;
   logic       regdst;
   logic       memtoreg;
   logic       regwrite;
   logic       memwrite;
   logic [2:0] alucontrol;
   logic       illegal;
   logic [3:0] state_dbg;

   modport master (
      input  op, funct, zero, mem_ready,
      output mem_req, iord, irwrite, pcen, pcsrc, alusrca, alusrcb,
             regdst, memtoreg, regwrite, memwrite, alucontrol, illegal, state_dbg
   );

   modport slave (
      output op, funct, zero, mem_ready,
      input  mem_req, iord, irwrite, pcen, pcsrc, alusrca, alusrcb,
             regdst, memtoreg, regwrite, memwrite, alucontrol, illegal, state_dbg
   );
endinterface

// File: rtl/multicycle_ctrl_alu_decoder.sv
// R-type funct to ALU control decode, with a flag for supported functs.
module alu_decoder
   import mips_ctrl_pkg::*;
(
   input  logic [5:0] funct,
   output alu_ctl_t   alucontrol,
   output logic       funct_ok
);

   always_comb begin
      alucontrol = ALU_ADD;
      funct_ok   = 1'b1;
      case (funct)
         FUNCT_ADD: alucontrol = ALU_ADD;
         FUNCT_SUB: alucontrol = ALU_SUB;
         FUNCT_AND: alucontrol = ALU_AND;
         FUNCT_OR:  alucontrol = ALU_OR;
         FUNCT_SLT: alucontrol = ALU_SLT;
         default:   funct_ok   = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the shared-memory MIPS-subset datapath.
//   state  | meaning
//   FETCH  | read instruction at PC, PC+4; waits on mem_ready
//   DECODE | compute branch target, dispatch on op (illegal -> FETCH)
//   MEMADR | rs + imm address for lw/sw
//   MEMRD  | data read; waits on mem_ready
//   MEMWB  | write memory data to rt
//   MEMWR  | data write; waits on mem_ready
//   EXEC   | R-type ALU op from funct
//   ALUWB  | write ALU result to rd
//   BRANCH | beq compare, take target when zero
//   ADDIEX | rs + imm
//   ADDIWB | write ALU result to rt
//   JUMP   | load jump target into PC
module multicycle_ctrl
   import mips_ctrl_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   multicycle_ctrl_if.master   bus
);

   state_t   state, next_state;
   alu_ctl_t funct_alu;
   logic     funct_ok;
   logic     mem_req_c, irwrite_c, pcen_c, regwrite_c, memwrite_c, illegal_c;

   alu_decoder u_alu_decoder (
      .funct      (bus.funct),
      .alucontrol (funct_alu),
      .funct_ok   (funct_ok)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_FETCH;
      else      state <= next_state;
   end

   always_comb begin
      next_state     = state;
      mem_req_c      = 1'b0;
      irwrite_c      = 1'b0;
      pcen_c         = 1'b0;
      regwrite_c     = 1'b0;
      memwrite_c     = 1'b0;
      illegal_c      = 1'b0;
      bus.iord       = 1'b0;
      bus.pcsrc      = PCSRC_ALU;
      bus.alusrca    = 1'b0;
      bus.alusrcb    = SRCB_RT;
      bus.regdst     = 1'b0;
      bus.memtoreg   = 1'b0;
      bus.alucontrol = ALU_AND;
      case (state)
         S_FETCH: begin
            mem_req_c      = 1'b1;
            bus.alusrcb    = SRCB_FOUR;
            bus.alucontrol = ALU_ADD;
            irwrite_c      = bus.mem_ready;
            pcen_c         = bus.mem_ready;
            if (bus.mem_ready) next_state = S_DECODE;
         end
         S_DECODE: begin
            bus.alusrcb    = SRCB_IMM_SH;
            bus.alucontrol = ALU_ADD;
            case (bus.op)
               OP_LW, OP_SW: next_state = S_MEMADR;
               OP_BEQ:       next_state = S_BRANCH;
               OP_ADDI:      next_state = S_ADDIEX;
               OP_J:         next_state = S_JUMP;
               OP_RTYPE: begin
                  if (funct_ok) begin
                     next_state = S_EXEC;
                  end else begin
                     next_state = S_FETCH;
                     illegal_c  = 1'b1;
                  end
               end
               default: begin
                  next_state = S_FETCH;
                  illegal_c  = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            bus.alusrca    = 1'b1;
            bus.alusrcb    = SRCB_IMM;
            bus.alucontrol = ALU_ADD;
            if (bus.op == OP_LW)      next_state = S_MEMRD;
            else if (bus.op == OP_SW) next_state = S_MEMWR;
            else                      next_state = S_FETCH;
         end
         S_MEMRD: begin
            mem_req_c = 1'b1;
            bus.iord  = 1'b1;
            if (bus.mem_ready) next_state = S_MEMWB;
         end
         S_MEMWB: begin
            regwrite_c   = 1'b1;
            bus.memtoreg = 1'b1;
            next_state   = S_FETCH;
         end
         S_MEMWR: begin
            mem_req_c  = 1'b1;
            bus.iord   = 1'b1;
            memwrite_c = 1'b1;
            if (bus.mem_ready) next_state = S_FETCH;
         end
         S_EXEC: begin
            bus.alusrca    = 1'b1;
            bus.alucontrol = funct_alu;
            next_state     = S_ALUWB;
         end
         S_ALUWB: begin
            regwrite_c = 1'b1;
            bus.regdst = 1'b1;
            next_state = S_FETCH;
         end
         S_BRANCH: begin
            bus.alusrca    = 1'b1;
            bus.alucontrol = ALU_SUB;
            bus.pcsrc      = PCSRC_ALUOUT;
            pcen_c         = bus.zero;
            next_state     = S_FETCH;
         end
         S_ADDIEX: begin
            bus.alusrca    = 1'b1;
            bus.alusrcb    = SRCB_IMM;
            bus.alucontrol = ALU_ADD;
            next_state     = S_ADDIWB;
         end
         S_ADDIWB: begin
            regwrite_c = 1'b1;
            next_state = S_FETCH;
         end
         S_JUMP: begin
            bus.pcsrc  = PCSRC_JUMP;
            pcen_c     = 1'b1;
            next_state = S_FETCH;
         end
         default: next_state = S_FETCH;
      endcase
   end

   // Side-effecting strobes are cut by rst directly so an in-flight write dies without a clock.
   assign bus.mem_req   = mem_req_c  & rst;
   assign bus.irwrite   = irwrite_c  & rst;
   assign bus.pcen      = pcen_c     & rst;
   assign bus.regwrite  = regwrite_c & rst;
   assign bus.memwrite  = memwrite_c & rst;
   assign bus.illegal   = illegal_c  & rst;
   assign bus.state_dbg = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-state checks of control outputs
// for each instruction class, stalls, illegal decode and async reset.
module tb_multicycle_ctrl;

   logic clk;
   logic rst;
   int   n_chk  = 0;
   int   n_pass = 0;

   multicycle_ctrl_if bus ();

   multicycle_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   logic [3:0] lw_states [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
   logic       lw_rw     [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

   initial begin
      rst           = 1'b0;
      bus.op        = 6'b000000;
      bus.funct     = 6'b000000;
      bus.zero      = 1'b0;
      bus.mem_ready = 1'b0;
      #3;
      chk("rst_state", bus.state_dbg, 4'd0);
      chk("rst_mem_req", bus.mem_req, 1'b0);
      chk("rst_irwrite", bus.irwrite, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("first_fetch_req", bus.mem_req, 1'b1);
      chk("first_fetch_ir_stalled", bus.irwrite, 1'b0);

      // lw, zero-wait memory: 0,1,2,3,4 then back to 0
      bus.op = 6'b100011;
      bus.mem_ready = 1'b1;
      #1;
      chk("lw_fetch_irwrite", bus.irwrite, 1'b1);
      chk("lw_fetch_pcen", bus.pcen, 1'b1);
      for (int i = 0; i < 5; i++) begin
         chk("lw_state", bus.state_dbg, lw_states[i]);
         chk("lw_regwrite", bus.regwrite, lw_rw[i]);
         if (i == 1) chk("lw_decode_srcb", bus.alusrcb, 2'b11);
         if (i == 2) chk("lw_memadr_srcb", bus.alusrcb, 2'b10);
         if (i == 3) chk("lw_memrd_iord", bus.iord, 1'b1);
         if (i == 4) begin
            chk("lw_wb_memtoreg", bus.memtoreg, 1'b1);
            chk("lw_wb_regdst", bus.regdst, 1'b0);
         end
         tick();
      end
      chk("lw_done", bus.state_dbg, 4'd0);

      // sw with 3 wait cycles in MEMWR: 7 cycles total
      bus.op = 6'b101011;
      tick();
      tick();
      tick();
      bus.mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("sw_wait_state", bus.state_dbg, 4'd5);
         chk("sw_wait_memwrite", bus.memwrite, 1'b1);
         tick();
      end
      bus.mem_ready = 1'b1;
      #1;
      chk("sw_last_memwrite", bus.memwrite, 1'b1);
      tick();
      chk("sw_done", bus.state_dbg, 4'd0);
      chk("sw_done_memwrite", bus.memwrite, 1'b0);

      // R-type slt
      bus.op = 6'b000000;
      bus.funct = 6'b101010;
      tick();
      tick();
      chk("slt_exec_state", bus.state_dbg, 4'd6);
      chk("slt_alucontrol", bus.alucontrol, 3'b111);
      chk("slt_exec_srca", bus.alusrca, 1'b1);
      tick();
      chk("slt_aluwb_state", bus.state_dbg, 4'd7);
      chk("slt_regdst", bus.regdst, 1'b1);
      chk("slt_regwrite", bus.regwrite, 1'b1);
      tick();
      chk("slt_done", bus.state_dbg, 4'd0);

      // R-type with unsupported funct
      bus.funct = 6'b000111;
      tick();
      chk("badfunct_illegal", bus.illegal, 1'b1);
      tick();
      chk("badfunct_back_fetch", bus.state_dbg, 4'd0);
      chk("badfunct_pulse_end", bus.illegal, 1'b0);
      chk("badfunct_no_regwrite", bus.regwrite, 1'b0);

      // unsupported opcode
      bus.op = 6'b111111;
      tick();
      chk("badop_illegal", bus.illegal, 1'b1);
      tick();
      chk("badop_back_fetch", bus.state_dbg, 4'd0);

      // beq taken then not taken
      bus.op = 6'b000100;
      bus.zero = 1'b1;
      tick();
      tick();
      chk("beq_t_state", bus.state_dbg, 4'd8);
      chk("beq_t_pcen", bus.pcen, 1'b1);
      chk("beq_t_pcsrc", bus.pcsrc, 2'b01);
      chk("beq_t_alu", bus.alucontrol, 3'b110);
      tick();
      chk("beq_t_done", bus.state_dbg, 4'd0);
      bus.zero = 1'b0;
      tick();
      tick();
      chk("beq_nt_pcen", bus.pcen, 1'b0);
      chk("beq_nt_pcsrc", bus.pcsrc, 2'b01);
      tick();
      chk("beq_nt_done", bus.state_dbg, 4'd0);

      // addi
      bus.op = 6'b001000;
      tick();
      tick();
      chk("addi_ex_state", bus.state_dbg, 4'd9);
      chk("addi_ex_srcb", bus.alusrcb, 2'b10);
      tick();
      chk("addi_wb_state", bus.state_dbg, 4'd10);
      chk("addi_wb_regwrite", bus.regwrite, 1'b1);
      chk("addi_wb_regdst", bus.regdst, 1'b0);
      tick();

      // fetch stall for 2 cycles, then j
      bus.op = 6'b000010;
      bus.mem_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("stall_state", bus.state_dbg, 4'd0);
         chk("stall_irwrite", bus.irwrite, 1'b0);
         chk("stall_pcen", bus.pcen, 1'b0);
         tick();
      end
      bus.mem_ready = 1'b1;
      #1;
      chk("stall_end_irwrite", bus.irwrite, 1'b1);
      chk("stall_end_pcen", bus.pcen, 1'b1);
      tick();
      chk("j_decode", bus.state_dbg, 4'd1);
      tick();
      chk("j_state", bus.state_dbg, 4'd11);
      chk("j_pcsrc", bus.pcsrc, 2'b10);
      chk("j_pcen", bus.pcen, 1'b1);
      tick();
      chk("j_done", bus.state_dbg, 4'd0);

      // async reset in the middle of a stalled MEMWR
      bus.op = 6'b101011;
      tick();
      tick();
      tick();
      bus.mem_ready = 1'b0;
      #1;
      chk("pre_rst_memwrite", bus.memwrite, 1'b1);
      rst = 1'b0;
      #1;
      chk("rst_kills_memwrite", bus.memwrite, 1'b0);
      chk("rst_state_memwr", bus.state_dbg, 4'd0);
      chk("rst_mem_req_low", bus.mem_req, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("post_rst_state", bus.state_dbg, 4'd0);
      chk("post_rst_mem_req", bus.mem_req, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control unit for the team's MIPS-subset CPU. It sequences a shared-memory datapath through fetch, decode, execute, memory and writeback states, one FSM state per clock. Memory access uses a req/ready handshake, so fetch and data access can both stall. It is the sequential counterpart to the single-cycle control decode and drives the same control vocabulary: regdst, alusrc, memtoreg, regwrite, memwrite, branch/jump and a 3-bit ALU control.

## Interface
- No parameters; all encodings are fixed in the package.
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- op  in  6  instruction[31:26], taken from the instruction register
- funct  in  6  instruction[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- iord  out  1  memory address select: 0 = PC, 1 = ALU result register
- irwrite  out  1  load the instruction register
- pcen  out  1  PC write enable
- pcsrc  out  2  next-PC select: 00 = ALU, 01 = ALU result register, 10 = jump target
- alusrca  out  1  ALU A select: 0 = PC, 1 = rs data
- alusrcb  out  2  ALU B select: 00 = rt data, 01 = 4, 10 = sign-extended imm, 11 = imm<<2
- regdst  out  1  register write address: 1 = rd, 0 = rt
- memtoreg  out  1  register write data: 1 = memory data register, 0 = ALU result register
- regwrite  out  1  register file write
- memwrite  out  1  memory write
- alucontrol  out  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt
- illegal  out  1  one-cycle pulse on an unsupported opcode or funct
- state_dbg  out  4  current state encoding

## Operation
- States: FETCH(0), DECODE(1), MEMADR(2), MEMRD(3), MEMWB(4), MEMWR(5), EXEC(6), ALUWB(7), BRANCH(8), ADDIEX(9), ADDIWB(10), JUMP(11).
- FETCH
  - Outputs: mem_req=1, iord=0, alusrca=0, alusrcb=01, alucontrol=add, pcsrc=00.
  - irwrite and pcen are asserted only when mem_ready=1; the state advances to DECODE only then. Otherwise the FSM holds in FETCH.
- DECODE
  - Outputs: alusrca=0, alusrcb=11, alucontrol=add; this computes the branch target.
  - Next state by op:
    - lw 100011 or sw 101011 -> MEMADR
    - R-type 000000 -> EXEC
    - beq 000100 -> BRANCH
    - addi 001000 -> ADDIEX
    - j 000010 -> JUMP
    - any other op -> FETCH with illegal=1
  - An R-type with funct outside {100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt} also goes to FETCH with illegal=1.
- MEMADR: alusrca=1, alusrcb=10, add. Next state is MEMRD for lw, MEMWR for sw.
- MEMRD: mem_req=1, iord=1. Holds until mem_ready, then goes to MEMWB.
- MEMWB: regwrite=1, regdst=0, memtoreg=1, then FETCH.
- MEMWR: mem_req=1, iord=1, memwrite=1. Holds until mem_ready, then goes to FETCH. memwrite stays high for every wait cycle.
- EXEC: alusrca=1, alusrcb=00, alucontrol from funct, then ALUWB.
- ALUWB: regwrite=1, regdst=1, memtoreg=0, then FETCH.
- BRANCH: alusrca=1, alusrcb=00, sub, pcsrc=01, pcen=zero, then FETCH.
- ADDIEX: alusrca=1, alusrcb=10, add, then ADDIWB.
- ADDIWB: regwrite=1, regdst=0, memtoreg=0, then FETCH.
- JUMP: pcsrc=10, pcen=1, then FETCH.
- Defaults: any output not listed for a state is 0.
- mem_ready outside FETCH, MEMRD or MEMWR is ignored.

## Timing
- Outputs are Moore: decoded combinationally from the state register. The exceptions are pcen/irwrite in FETCH, which are gated by mem_ready, and pcen in BRANCH, which follows zero. alucontrol in EXEC follows funct.
- Cycles per instruction with zero-wait memory:
  - lw 5
  - sw 4
  - R-type 4
  - addi 4
  - beq 3
  - j 3
- Each mem_ready-low cycle adds one cycle.
- Reset:
  - rst low forces the state to FETCH asynchronously.
  - While rst is low, mem_req, irwrite, pcen, regwrite, memwrite and illegal are forced to 0.
  - state_dbg=0 during reset.
- The first fetch request occurs in the first cycle after rst rises.
- Reset asserted during MEMWR removes memwrite in the same cycle, with no clock edge required.
- illegal is high for exactly the one DECODE cycle.

## Structure
- Package mips_ctrl_pkg holds:
  - opcode and funct constants
  - the state enum (4 bits)
  - the ALU control codes
  - the alusrcb and pcsrc encodings
- One sub-module, alu_decoder: combinational funct -> alucontrol plus a funct-valid flag.
- The state register and next-state/output logic live in multicycle_ctrl.

## Test plan
- Reset: rst low mid-MEMWR with memwrite=1 -> memwrite=0 immediately; after release, state_dbg=0, mem_req=1.
- lw, op=100011, mem_ready always 1 -> states 0,1,2,3,4,0. regwrite=1 with memtoreg=1 and regdst=0 only in cycle 5.
- sw with mem_ready low for 3 cycles in MEMWR -> memwrite high for 4 consecutive cycles, then FETCH. Total 7 cycles.
- R-type, funct=101010 -> alucontrol=111 in EXEC, then ALUWB with regdst=1. funct=000111 -> illegal pulse in DECODE, then FETCH, with no regwrite.
- beq: zero=1 -> pcen=1, pcsrc=01 in BRANCH. zero=0 -> pcen=0. Both return to FETCH after 3 cycles.
- Fetch stall: mem_ready low for 2 cycles in FETCH -> irwrite=pcen=0 and the state holds. On the mem_ready=1 cycle, irwrite=pcen=1, then DECODE. j, op=000010 -> pcsrc=10, pcen=1.
